// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, device/ALU constants and IR field placement for the control sequencer.
package control_sequencer_pkg;

  localparam int op_dev_eq_alu      = 0;
  localparam int op_dev_eq_const8   = 1;
  localparam int op_devp_eq_const16 = 2;
  localparam int op_dev_eq_rom_abs  = 4;
  localparam int op_dev_eq_ram_abs  = 5;
  localparam int op_ram_abs_eq_dev  = 6;

  localparam int DEV_ROM   = 1;
  localparam int DEV_RAM   = 2;
  localparam int ALU_PASSL = 1;
  localparam int ALU_PASSR = 2;

  // Fixed bus-select field positions inside the low part of the IR
  localparam int RBUS_LSB     = 5;
  localparam int LBUS_LSB     = 9;
  localparam int LBUS_ABS_LSB = 16;

  function automatic int op_lsb(input int rom_w, input int op_w);
    return rom_w - op_w;
  endfunction

  function automatic int targ_lsb(input int rom_w, input int op_w, input int targ_w);
    return rom_w - op_w - targ_w;
  endfunction

  function automatic bit fields_overlap(input int rom_w, input int op_w,
                                        input int targ_w, input int addr_w);
    return rom_w < (op_w + targ_w + addr_w);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ROM-side inputs and decoded control outputs of the control sequencer.
interface control_sequencer_if #(
  parameter int NPHASE  = 4,
  parameter int ROM_W   = 24,
  parameter int TARG_W  = 5,
  parameter int BUS_W   = 4,
  parameter int ALUOP_W = 5,
  parameter int ADDR_W  = 16
);
  localparam int PH_W = $clog2(NPHASE);

  logic               stall;
  logic [ROM_W-1:0]   rom_data;
  logic [PH_W-1:0]    phase;
  logic               _addrmode_pc;
  logic               _addrmode_register;
  logic               _addrmode_direct;
  logic [ADDR_W-1:0]  direct_addr;
  logic [BUS_W-1:0]   rbus_dev;
  logic [BUS_W-1:0]   lbus_dev;
  logic [TARG_W-1:0]  targ_dev;
  logic [ALUOP_W-1:0] aluop;
  logic               _targ_we;
  logic               illegal;

  modport master (
    input  stall, rom_data,
    output phase, _addrmode_pc, _addrmode_register, _addrmode_direct,
           direct_addr, rbus_dev, lbus_dev, targ_dev, aluop, _targ_we, illegal
  );

  modport slave (
    output stall, rom_data,
    input  phase, _addrmode_pc, _addrmode_register, _addrmode_direct,
           direct_addr, rbus_dev, lbus_dev, targ_dev, aluop, _targ_we, illegal
  );
endinterface

// File: rtl/control_sequencer_phase_counter.sv
// Instruction phase counter: 0..NPHASE-1, frozen by stall, synchronous reset to fetch.
module phase_counter #(
  parameter int NPHASE = 4
) (
  input  logic                      clk,
  input  logic                      MR,
  input  logic                      stall,
  output logic [$clog2(NPHASE)-1:0] phase,
  output logic                      is_fetch,
  output logic                      is_last
);
  localparam int PH_W = $clog2(NPHASE);
  localparam logic [PH_W-1:0] LAST = PH_W'(NPHASE - 1);

  logic [PH_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (!stall) phase_d = (phase_q == LAST) ? '0 : phase_q + PH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (MR) phase_q <= '0;
    else    phase_q <= phase_d;
  end

  assign phase    = phase_q;
  assign is_fetch = (phase_q == '0);
  assign is_last  = (phase_q == LAST);
endmodule

// File: rtl/control_sequencer.sv
// Phased control sequencer: latches the ROM word into IR during fetch and decodes
// addressing mode, bus selects, ALU op and the write strobe from (phase, IR).
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NPHASE  = 4,
  parameter int ROM_W   = 24,
  parameter int OP_W    = 3,
  parameter int TARG_W  = 5,
  parameter int BUS_W   = 4,
  parameter int ALUOP_W = 5,
  parameter int ADDR_W  = 16
) (
  input logic                 clk,
  input logic                 MR,
  control_sequencer_if.master bus
);
  localparam int PH_W     = $clog2(NPHASE);
  localparam int OP_LSB   = op_lsb(ROM_W, OP_W);
  localparam int TARG_LSB = targ_lsb(ROM_W, OP_W, TARG_W);

  if (fields_overlap(ROM_W, OP_W, TARG_W, ADDR_W)) begin : g_bad_fields
    $error("control_sequencer: opcode, target and address fields overlap in ROM_W");
  end
  if (NPHASE < 3) begin : g_bad_nphase
    $error("control_sequencer: NPHASE must be at least 3");
  end

  logic [ROM_W-1:0]   ir_q, ir_d;
  logic [PH_W-1:0]    phase;
  logic               is_fetch, is_last;
  logic [OP_W-1:0]    op;

  logic               mode_pc_n, mode_reg_n, mode_dir_n;
  logic [BUS_W-1:0]   rbus, lbus;
  logic [TARG_W-1:0]  targ;
  logic [ALUOP_W-1:0] alu;
  logic               we_n, illegal_op;

  phase_counter #(.NPHASE(NPHASE)) u_phase (
    .clk      (clk),
    .MR       (MR),
    .stall    (bus.stall),
    .phase    (phase),
    .is_fetch (is_fetch),
    .is_last  (is_last)
  );

  // IR only changes on the edge leaving fetch, so decode is stable for the whole instruction
  assign ir_d = (is_fetch && !bus.stall) ? bus.rom_data : ir_q;

  always_ff @(posedge clk) begin
    if (MR) ir_q <= '0;
    else    ir_q <= ir_d;
  end

  assign op = ir_q[OP_LSB +: OP_W];

  always_comb begin
    mode_pc_n  = 1'b1;
    mode_reg_n = 1'b1;
    mode_dir_n = 1'b1;
    rbus       = '0;
    lbus       = '0;
    targ       = '0;
    alu        = '0;
    we_n       = 1'b1;
    illegal_op = 1'b0;
    if (is_fetch) begin
      mode_pc_n = 1'b0;
    end else begin
      targ = ir_q[TARG_LSB +: TARG_W];
      case (op)
        OP_W'(op_dev_eq_alu): begin
          mode_reg_n = 1'b0;
          rbus       = ir_q[RBUS_LSB +: BUS_W];
          lbus       = ir_q[LBUS_LSB +: BUS_W];
          alu        = ir_q[ALUOP_W-1:0];
        end
        OP_W'(op_dev_eq_const8), OP_W'(op_devp_eq_const16): begin
          mode_reg_n = 1'b0;
          rbus       = BUS_W'(DEV_ROM);
          alu        = ALUOP_W'(ALU_PASSR);
        end
        OP_W'(op_dev_eq_rom_abs): begin
          mode_dir_n = 1'b0;
          rbus       = BUS_W'(DEV_ROM);
          alu        = ALUOP_W'(ALU_PASSR);
        end
        OP_W'(op_dev_eq_ram_abs): begin
          mode_dir_n = 1'b0;
          rbus       = BUS_W'(DEV_RAM);
          alu        = ALUOP_W'(ALU_PASSR);
        end
        OP_W'(op_ram_abs_eq_dev): begin
          mode_dir_n = 1'b0;
          lbus       = ir_q[LBUS_ABS_LSB +: BUS_W];
          alu        = ALUOP_W'(ALU_PASSL);
          targ       = TARG_W'(DEV_RAM);
        end
        default: begin
          // Unused opcode: park on a harmless register-mode cycle with no write
          mode_reg_n = 1'b0;
          targ       = '0;
          illegal_op = 1'b1;
        end
      endcase
      // Strobe waits for the unstalled last-phase cycle so it fires exactly once
      if (is_last && !illegal_op && !bus.stall) we_n = 1'b0;
    end
  end

  assign bus.phase              = phase;
  assign bus._addrmode_pc       = mode_pc_n;
  assign bus._addrmode_register = mode_reg_n;
  assign bus._addrmode_direct   = mode_dir_n;
  assign bus.direct_addr        = ir_q[ADDR_W-1:0];
  assign bus.rbus_dev           = rbus;
  assign bus.lbus_dev           = lbus;
  assign bus.targ_dev           = targ;
  assign bus.aluop              = alu;
  assign bus._targ_we           = we_n;
  assign bus.illegal            = illegal_op;
endmodule
